// File: rtl/prefetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory req/ack, redirect, and decode valid/ready.
interface prefetch_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ILEN  = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [ILEN-1:0] imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic [ILEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;
  logic [CW-1:0]   fifo_count;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, fifo_count,
    input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, fifo_count,
    output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one request at a time,
// buffers returned words in a fall-through queue and flushes on redirect.
module prefetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             rst,
  prefetch_unit_if.master bus
);
  localparam int unsigned     PW     = $clog2(DEPTH);
  localparam int unsigned     CW     = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] PC_INC = XLEN'(ILEN / 8);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [ILEN-1:0] inst_mem [DEPTH];

  logic            push;
  logic            pop;
  logic [CW-1:0]   count_nxt;
  logic [XLEN-1:0] redirect_pc_al;

  // Redirect outranks both queue ports in the same cycle.
  assign push           = (state_q == S_WAIT) && bus.imem_ack && !bus.redirect;
  assign pop            = valid_q && bus.inst_ready && !bus.redirect;
  assign count_nxt      = count_q + CW'(push) - CW'(pop);
  assign redirect_pc_al = bus.redirect_pc & ~XLEN'(2'b11);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.redirect && (count_nxt < CW'(DEPTH))) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.redirect)      state_d = bus.imem_ack ? S_IDLE : S_DISCARD;
        else if (bus.imem_ack) state_d = (count_nxt < CW'(DEPTH)) ? S_WAIT : S_IDLE;
      end
      S_DISCARD: begin
        if (bus.imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The address freezes in DISCARD so the stale request completes unchanged.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_nxt;
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    if (push) fetch_pc_d = fetch_pc_q + PC_INC;
    if (bus.redirect) begin
      fetch_pc_d = redirect_pc_al;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
    req_d   = (state_d == S_WAIT) || (state_d == S_DISCARD);
    addr_d  = (state_d == S_DISCARD) ? addr_q : fetch_pc_d;
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      inst_mem[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst       = inst_mem[rd_ptr_q];
  assign bus.inst_pc    = pc_mem[rd_ptr_q];
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: cycle vectors plus reset and slow-ack redirect sequences.
module tb_prefetch_unit;
  localparam logic [31:0] MAGIC = 32'hA5A50000;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  prefetch_unit_if #(.XLEN(32), .ILEN(32), .DEPTH(4)) bus ();

  prefetch_unit #(.XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: returned word is a function of the requested address.
  assign bus.imem_rdata = bus.imem_addr ^ MAGIC;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        ready;
    logic        ack;
    logic        redir;
    logic [31:0] rpc;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
    logic [2:0]  ecnt;
  } vec_t;

  vec_t vecs [28];

  function automatic vec_t mk(logic ready, logic ack, logic redir, logic [31:0] rpc,
                              logic ereq, logic [31:0] eaddr, logic evalid,
                              logic [31:0] epc, logic [2:0] ecnt);
    vec_t v;
    v.ready = ready; v.ack = ack; v.redir = redir; v.rpc = rpc;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.epc = epc; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_state(input string tag, input logic ereq, input logic [31:0] eaddr,
                           input logic evalid, input logic [31:0] epc, input logic [2:0] ecnt);
    chk({tag, ".req"},   32'(bus.imem_req),   32'(ereq));
    chk({tag, ".addr"},  bus.imem_addr,       eaddr);
    chk({tag, ".valid"}, 32'(bus.inst_valid), 32'(evalid));
    chk({tag, ".count"}, 32'(bus.fifo_count), 32'(ecnt));
    if (evalid) begin
      chk({tag, ".pc"},   bus.inst_pc, epc);
      chk({tag, ".inst"}, bus.inst,    epc ^ MAGIC);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    // ready ack redir rpc | req addr valid head_pc count (after the next edge)
    vecs[0]  = mk(1, 1, 0, 0,         1, 32'h000, 0, 0,       0);
    vecs[1]  = mk(1, 1, 0, 0,         1, 32'h004, 1, 32'h000, 1);
    vecs[2]  = mk(1, 1, 0, 0,         1, 32'h008, 1, 32'h004, 1);
    vecs[3]  = mk(1, 1, 0, 0,         1, 32'h00C, 1, 32'h008, 1);
    vecs[4]  = mk(0, 1, 0, 0,         1, 32'h010, 1, 32'h008, 2);
    vecs[5]  = mk(0, 1, 0, 0,         1, 32'h014, 1, 32'h008, 3);
    vecs[6]  = mk(0, 1, 0, 0,         0, 32'h018, 1, 32'h008, 4);
    vecs[7]  = mk(0, 1, 0, 0,         0, 32'h018, 1, 32'h008, 4);
    vecs[8]  = mk(1, 1, 0, 0,         1, 32'h018, 1, 32'h00C, 3);
    vecs[9]  = mk(1, 1, 0, 0,         1, 32'h01C, 1, 32'h010, 3);
    vecs[10] = mk(1, 0, 0, 0,         1, 32'h01C, 1, 32'h014, 2);
    vecs[11] = mk(1, 0, 0, 0,         1, 32'h01C, 1, 32'h018, 1);
    vecs[12] = mk(1, 0, 0, 0,         1, 32'h01C, 0, 0,       0);
    vecs[13] = mk(0, 1, 0, 0,         1, 32'h020, 1, 32'h01C, 1);
    vecs[14] = mk(1, 0, 1, 32'h103,   1, 32'h020, 0, 0,       0);
    vecs[15] = mk(1, 0, 0, 0,         1, 32'h020, 0, 0,       0);
    vecs[16] = mk(1, 1, 0, 0,         0, 32'h100, 0, 0,       0);
    vecs[17] = mk(1, 1, 0, 0,         1, 32'h100, 0, 0,       0);
    vecs[18] = mk(0, 1, 0, 0,         1, 32'h104, 1, 32'h100, 1);
    vecs[19] = mk(0, 1, 0, 0,         1, 32'h108, 1, 32'h100, 2);
    vecs[20] = mk(0, 1, 0, 0,         1, 32'h10C, 1, 32'h100, 3);
    vecs[21] = mk(1, 0, 1, 32'h200,   1, 32'h10C, 0, 0,       0);
    vecs[22] = mk(1, 1, 0, 0,         0, 32'h200, 0, 0,       0);
    vecs[23] = mk(1, 1, 0, 0,         1, 32'h200, 0, 0,       0);
    vecs[24] = mk(1, 1, 1, 32'h300,   0, 32'h300, 0, 0,       0);
    vecs[25] = mk(1, 1, 1, 32'h404,   0, 32'h404, 0, 0,       0);
    vecs[26] = mk(1, 1, 0, 0,         1, 32'h404, 0, 0,       0);
    vecs[27] = mk(1, 1, 0, 0,         1, 32'h408, 1, 32'h404, 1);

    rst             = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = 1'b0;
    step();
    step();
    chk_state("reset", 0, 32'h0, 0, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < 28; i++) begin
      bus.inst_ready  = vecs[i].ready;
      bus.imem_ack    = vecs[i].ack;
      bus.redirect    = vecs[i].redir;
      bus.redirect_pc = vecs[i].rpc;
      step();
      chk_state($sformatf("vec%0d", i), vecs[i].ereq, vecs[i].eaddr, vecs[i].evalid,
                vecs[i].epc, vecs[i].ecnt);
    end
    bus.redirect = 1'b0;

    // Asynchronous reset while a request is outstanding.
    #2 rst = 1'b0;
    #1 chk_state("async_rst", 0, 32'h0, 0, 0, 0);
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.inst_ready = 1'b0;
    rst            = 1'b1;
    step();
    chk_state("restart", 1, 32'h0, 0, 0, 0);

    // Slow memory: redirect one cycle into the request, stale word must be dropped.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect    = 1'b0;
    chk_state("slow.redir", 1, 32'h0, 0, 0, 0);
    step();
    chk_state("slow.hold", 1, 32'h0, 0, 0, 0);
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    chk_state("slow.stale", 0, 32'h100, 0, 0, 0);
    step();
    chk_state("slow.issue", 1, 32'h100, 0, 0, 0);
    step();
    chk_state("slow.w1", 1, 32'h100, 0, 0, 0);
    step();
    chk_state("slow.w2", 1, 32'h100, 0, 0, 0);
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    chk_state("slow.first", 1, 32'h104, 1, 32'h100, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prefetch_unit.md
Name: prefetch_unit

Overview:
Parametrised instruction-fetch front end for the next-generation core. It replaces the fixed single-cycle program counter and instruction-memory coupling. It owns the fetch PC and issues requests to a variable-latency instruction memory over a req/ack handshake. Returned words go into a DEPTH-entry prefetch queue of {pc, instruction}. Decode drains the queue over a valid/ready interface, and a redirect input (branch/jump resolved downstream) flushes the queue and restarts fetch.

Parameters:
XLEN, 32, address/PC width in bits
ILEN, 32, instruction width in bits
DEPTH, 4, prefetch queue entries; power of two, >= 2
RESET_PC, 0, fetch PC loaded on reset (low 2 bits must be 0)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
imem_req  output  1  fetch request, held until imem_ack
imem_addr  output  XLEN  fetch address, stable while imem_req=1
imem_ack  input  1  request completed; imem_rdata valid this cycle
imem_rdata  input  ILEN  fetched instruction
redirect  input  1  flush queue and restart fetch at redirect_pc
redirect_pc  input  XLEN  new fetch PC; bits [1:0] forced to 0 internally
inst_valid  output  1  queue head valid
inst  output  ILEN  queue head instruction
inst_pc  output  XLEN  queue head PC
inst_ready  input  1  consumer accepts head when inst_valid=1
fifo_count  output  clog2(DEPTH+1)  current queue occupancy

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; fetch_pc=RESET_PC; count=0; rd/wr pointers=0; imem_req=0; imem_addr=RESET_PC; inst_valid=0; fifo_count=0. Queue contents are don't-care.
- imem_req, imem_addr: registered outputs. imem_req=1 exactly in states WAIT and DISCARD. imem_addr=fetch_pc.
- At most one outstanding request at any time.
- IDLE: if redirect, fetch_pc<=redirect_pc and stay IDLE. Else if count_next<DEPTH, go to WAIT; imem_req rises the next cycle with addr=fetch_pc.
- WAIT, imem_ack=1, no redirect: push {fetch_pc, imem_rdata}; fetch_pc<=fetch_pc+ILEN/8 (wraps modulo 2^XLEN). If count after push and pop <DEPTH, stay WAIT (back-to-back, one word/cycle at zero-latency ack). Otherwise go to IDLE.
- WAIT, redirect=1: flush; fetch_pc<=redirect_pc. If imem_ack=1 the same cycle, the data is dropped and the next state is IDLE. Otherwise go to DISCARD.
- DISCARD: imem_req stays 1 with the old address (handshake must not be broken). On imem_ack the data is dropped and the next state is IDLE. A redirect in DISCARD updates fetch_pc only and stays in DISCARD.
- imem_ack in IDLE is ignored.
- Queue is first-word-fall-through. inst_valid=(count!=0); inst/inst_pc=head entry combinationally.
- Pop when inst_valid && inst_ready. Push and pop in the same cycle leave count unchanged. Push never occurs when count==DEPTH, because the issue rule guarantees space.
- Redirect has priority over push and pop in the same cycle: count<=0 and pointers reset. inst_valid=0 the next cycle.
- First instruction after reset with ack tied high: req at cycle 1, inst_valid at cycle 2.
- Redirect to first new instruction, zero-latency memory, from WAIT without ack: DISCARD -> IDLE -> WAIT -> valid, minimum 3 cycles after the stale ack.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.

Test Plan:
- Reset release, RESET_PC=0, imem_ack=1, imem_rdata=addr^0xA5A50000, inst_ready=1 -> inst_pc 0x0, 0x4, 0x8... one per cycle from cycle 2, with matching inst values.
- inst_ready=0, ack=1, DEPTH=4 -> fifo_count reaches 4, imem_req drops, heads 0x0..0xC retained. Raise ready -> drains in order, fetch resumes at 0x10, no loss or duplication.
- Ack latency 3 cycles, redirect to 0x100 one cycle after req -> imem_addr held until ack, stale word not enqueued, next imem_addr=0x100, first inst_pc=0x100.
- 3 entries queued, redirect and pop in the same cycle -> next cycle fifo_count=0, inst_valid=0.
- redirect_pc=0x103 -> next issued imem_addr=0x100.
- rst asserted mid-WAIT -> imem_req=0, inst_valid=0, fifo_count=0 immediately without a clock edge. After release, fetch restarts at RESET_PC.
